// File: rtl/fir_out_requant_decim.sv
`default_nettype none
// ============================================================================
// Module   : fir_out_requant_decim
// Purpose  : Output stage of the 63-tap FIR. Rounds and shifts the 32-bit
//            filter result to 16 bits with saturation, keeps one sample in
//            every DECIM, and buffers kept samples in a show-ahead FIFO that
//            drives a valid/ready consumer.
// Revision : 1.0 - initial release
// ============================================================================
module fir_out_requant_decim #(
    parameter int SHIFT = 8,
    parameter int DECIM = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [31:0]              in_data,
    input  logic                     clr,
    output logic                     m_valid,
    output logic [15:0]              m_data,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     sat_flag,
    output logic                     drop_flag
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [c_PW-1:0] c_PHASE_LAST = c_PW'(DECIM - 1);
    localparam logic [c_AW:0]   c_FULL       = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]   c_ONE        = (c_AW + 1)'(1);
    // Half an output LSB, so the arithmetic shift rounds half toward +inf.
    localparam logic signed [32:0] c_RND =
        (SHIFT > 0) ? (33'sd1 <<< ((SHIFT > 0) ? (SHIFT - 1) : 0)) : 33'sd0;

    logic signed [32:0] w_sum;
    logic signed [32:0] w_shr;
    logic [15:0]        w_res;
    logic               w_sat;
    logic               w_keep;
    logic               w_pop;
    logic               w_full;
    logic               w_wr;
    logic               w_drop;
    logic [c_AW-1:0]    w_rd_next;

    logic [c_PW-1:0]    r_phase;
    logic               r_s1_valid;
    logic [15:0]        r_s1_data;
    logic               r_s1_sat;
    logic [15:0]        r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_AW:0]      r_level;
    logic [15:0]        r_m_data;
    logic               r_sat_flag;
    logic               r_drop_flag;

    // 33-bit sum cannot overflow: max input plus max rounding offset fits.
    assign w_sum = $signed({in_data[31], in_data}) + c_RND;
    assign w_shr = w_sum >>> SHIFT;

    // Clamp the shifted value into the signed 16-bit range.
    always_comb begin
        w_sat = 1'b0;
        w_res = w_shr[15:0];
        if (w_shr > 33'sd32767) begin
            w_res = 16'h7FFF;
            w_sat = 1'b1;
        end else if (w_shr < -33'sd32768) begin
            w_res = 16'h8000;
            w_sat = 1'b1;
        end
    end

    assign w_keep    = in_valid & (r_phase == '0);
    assign w_pop     = (r_level != '0) & m_ready;
    assign w_full    = (r_level == c_FULL);
    // A full FIFO still accepts the write when the head leaves on the same edge.
    assign w_wr      = r_s1_valid & (~w_full | w_pop);
    assign w_drop    = r_s1_valid & w_full & ~w_pop;
    assign w_rd_next = r_rd_ptr + 1'b1;

    // Decimation phase and the stage-1 register holding the kept sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase    <= '0;
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_sat   <= 1'b0;
        end else if (clr) begin
            r_phase    <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            if (in_valid) begin
                r_phase <= (r_phase == c_PHASE_LAST) ? '0 : r_phase + 1'b1;
            end
            r_s1_valid <= w_keep;
            if (w_keep) begin
                r_s1_data <= w_res;
                r_s1_sat  <= w_sat;
            end
        end
    end

    // FIFO storage; stale entries are harmless since pointers are reset.
    always_ff @(posedge clk) begin
        if (w_wr && !clr) begin
            r_mem[r_wr_ptr] <= r_s1_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + c_ONE;
                2'b01:   r_level <= r_level - c_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Registered show-ahead head: next entry on pop, incoming sample when
    // the FIFO is (or becomes) empty, otherwise hold the last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_data <= '0;
        end else if (!clr) begin
            if (w_pop && (r_level > c_ONE)) begin
                r_m_data <= r_mem[w_rd_next];
            end else if (w_wr && ((r_level == '0) || (w_pop && (r_level == c_ONE)))) begin
                r_m_data <= r_s1_data;
            end
        end
    end

    // Sticky status flags, updated when a kept sample leaves stage 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_flag  <= 1'b0;
            r_drop_flag <= 1'b0;
        end else if (clr) begin
            r_sat_flag  <= 1'b0;
            r_drop_flag <= 1'b0;
        end else begin
            if (r_s1_valid && r_s1_sat) begin
                r_sat_flag <= 1'b1;
            end
            if (w_drop) begin
                r_drop_flag <= 1'b1;
            end
        end
    end

    assign m_valid   = (r_level != '0);
    assign m_data    = r_m_data;
    assign level     = r_level;
    assign sat_flag  = r_sat_flag;
    assign drop_flag = r_drop_flag;

endmodule
`default_nettype wire

// File: tb/tb_fir_out_requant_decim.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_out_requant_decim
// Purpose  : Scoreboard bench for fir_out_requant_decim. Two instances share
//            the clock and reset: one without decimation, one with DECIM=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_out_requant_decim;

    localparam int SHIFT = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        v1, c1, r1, v4, c4, r4;
    logic [31:0] d1, d4;
    logic        m1_valid, m4_valid, sat1, sat4, drop1, drop4;
    logic [15:0] m1_data, m4_data;
    logic [2:0]  lvl1, lvl4;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] q1 [$];
    logic [15:0] q4 [$];
    logic [15:0] e1, e4;
    int          max4 = 0;

    fir_out_requant_decim #(.SHIFT(SHIFT), .DECIM(1), .DEPTH(DEPTH)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_data(d1), .clr(c1),
        .m_valid(m1_valid), .m_data(m1_data), .m_ready(r1), .level(lvl1),
        .sat_flag(sat1), .drop_flag(drop1)
    );

    fir_out_requant_decim #(.SHIFT(SHIFT), .DECIM(4), .DEPTH(DEPTH)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_data(d4), .clr(c4),
        .m_valid(m4_valid), .m_data(m4_data), .m_ready(r4), .level(lvl4),
        .sat_flag(sat4), .drop_flag(drop4)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference requantiser: round half up, shift, clamp to int16.
    function automatic logic [15:0] req(input logic [31:0] x);
        longint t;
        t = longint'($signed(x)) + (longint'(1) << (SHIFT - 1));
        t = t >>> SHIFT;
        if (t > 32767)  return 16'h7FFF;
        if (t < -32768) return 16'h8000;
        return t[15:0];
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Compare every accepted output against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m1_valid && r1) begin
                if (q1.size() == 0) check("d1_unexpected_out", 32'd1, 32'd0);
                else begin
                    e1 = q1.pop_front();
                    check("d1_data", {16'h0, m1_data}, {16'h0, e1});
                end
            end
            if (m4_valid && r4) begin
                if (q4.size() == 0) check("d4_unexpected_out", 32'd1, 32'd0);
                else begin
                    e4 = q4.pop_front();
                    check("d4_data", {16'h0, m4_data}, {16'h0, e4});
                end
            end
            if (int'(lvl4) > max4) max4 = int'(lvl4);
        end
    end

    initial begin
        rst_n = 1'b0;
        v1 = 0; c1 = 0; r1 = 0; d1 = '0;
        v4 = 0; c4 = 0; r4 = 0; d4 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", m1_valid, 0);
        check("rst_data",  m1_data,  0);
        check("rst_level", lvl1,     0);
        check("rst_sat",   sat1,     0);
        check("rst_drop",  drop1,    0);
        rst_n = 1'b1;
        step();

        // Rounding, no decimation, 2-cycle latency.
        r1 = 1;
        v1 = 1; d1 = 32'd384;  q1.push_back(16'd2);
        step(); check("lat_edge1", m1_valid, 0);
        d1 = -32'sd384;        q1.push_back(16'hFFFF);
        step(); check("lat_edge2", m1_valid, 1);
        d1 = 32'd127;          q1.push_back(16'd0);
        step();
        d1 = -32'sd129;        q1.push_back(16'hFFFF);
        step();
        v1 = 0;
        step(4);
        check("t1_sat",   sat1, 0);
        check("t1_level", lvl1, 0);

        // Saturation at both rails.
        v1 = 1; d1 = 32'h7FFFFFFF; q1.push_back(16'h7FFF);
        step(); check("t2_sat_edge1", sat1, 0);
        d1 = 32'h80000000;         q1.push_back(16'h8000);
        step(); check("t2_sat_edge2", sat1, 1);
        v1 = 0;
        step(4);
        check("t2_drained", q1.size(), 0);

        // Decimation by 4 at full input rate.
        r4 = 1; max4 = 0;
        for (int k = 0; k < 12; k++) begin
            v4 = 1; d4 = 32'(256 * k);
            if (k % 4 == 0) q4.push_back(req(d4));
            step();
        end
        v4 = 0;
        step(4);
        check("t3_peak_level", max4, 1);
        check("t3_drained", q4.size(), 0);

        // Fill past capacity with the consumer stalled.
        r1 = 0;
        for (int i = 0; i < 6; i++) begin
            v1 = 1; d1 = 32'(256 * (i + 1));
            if (i < DEPTH) q1.push_back(req(d1));
            step();
        end
        v1 = 0;
        step(2);
        check("t4_level", lvl1,     4);
        check("t4_drop",  drop1,    1);
        check("t4_valid", m1_valid, 1);
        check("t4_head",  m1_data,  1);

        // Full FIFO: write and pop on the same edge.
        v1 = 1; d1 = 32'(256 * 7); q1.push_back(req(d1));
        step();
        v1 = 0; r1 = 1;
        step();
        check("t5_level", lvl1,    4);
        check("t5_head",  m1_data, 2);
        step(6);
        check("t5_level_empty", lvl1,      0);
        check("t5_valid_low",   m1_valid,  0);
        check("t5_drained",     q1.size(), 0);

        // Synchronous clear with level 3 and phase 2.
        r4 = 0;
        for (int k = 0; k < 10; k++) begin
            v4 = 1;
            d4 = (k == 0) ? 32'h7FFFFFFF : 32'(256 * (k + 10));
            if (k % 4 == 0) q4.push_back(req(d4));
            step();
        end
        v4 = 0;
        step(2);
        check("t6_level_pre", lvl4, 3);
        check("t6_sat_pre",   sat4, 1);
        c4 = 1; v4 = 1; d4 = 32'(256 * 50);
        step();
        c4 = 0; v4 = 0;
        q4.delete();
        check("t6_level", lvl4,     0);
        check("t6_valid", m4_valid, 0);
        check("t6_sat",   sat4,     0);
        check("t6_drop",  drop4,    0);
        v4 = 1; d4 = 32'(256 * 33); q4.push_back(16'd33);
        step();
        v4 = 0;
        check("t6_lat_edge1", m4_valid, 0);
        step();
        check("t6_lat_edge2", m4_valid, 1);
        check("t6_data",      m4_data,  33);
        r4 = 1;
        step(2);
        check("t6_drained", q4.size(), 0);

        // Asynchronous reset in the middle of a burst.
        r1 = 0;
        for (int i = 0; i < 3; i++) begin
            v1 = 1; d1 = 32'(256 * (i + 1));
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        check("t7_valid", m1_valid, 0);
        check("t7_data",  m1_data,  0);
        check("t7_level", lvl1,     0);
        check("t7_sat",   sat1,     0);
        check("t7_drop",  drop1,    0);
        q1.delete();
        q4.delete();
        v1 = 0;
        step();
        rst_n = 1'b1;
        step(3);
        check("t7_flushed", lvl1, 0);
        check("end_q1", q1.size(), 0);
        check("end_q4", q4.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_out_requant_decim.md
Name: fir_out_requant_decim

Overview:
Downstream stage of the 63-tap FIR filter block. Takes the 32-bit signed full-precision filter output and rounds/shifts it to 16 bits with saturation. It keeps one sample in every DECIM and buffers kept samples in a small FIFO. The FIFO feeds the next consumer (DAC interface / output serializer) over a valid/ready handshake.

Parameters:
SHIFT, 8, arithmetic right-shift applied to the 32-bit input before saturation (0..16)
DECIM, 4, decimation ratio; 1 = no decimation (1..256)
DEPTH, 4, FIFO depth in entries; power of two (2..16)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  in_data is a new filter sample this cycle (FIR ena delayed one cycle)
in_data  input  32  signed FIR output sample
clr  input  1  synchronous clear of FIFO, decimation phase and sticky flags
m_valid  output  1  FIFO head holds a sample
m_data  output  16  signed sample at FIFO head
m_ready  input  1  consumer accepts m_data when m_valid & m_ready
level  output  log2(DEPTH)+1  current FIFO occupancy
sat_flag  output  1  sticky: a kept sample was saturated
drop_flag  output  1  sticky: a kept sample was lost because the FIFO was full

Behaviour:
- Reset (async, rst_n=0):
  - m_valid=0, m_data=0, level=0, sat_flag=0, drop_flag=0.
  - Decimation phase=0; stage-1 register invalid.
- Reset mid-operation discards all buffered and in-flight samples immediately.
- Arithmetic, computed in 33 bits:
  - t = in_data + (SHIFT>0 ? 2^(SHIFT-1) : 0), i.e. round half toward +inf.
  - r = t >>> SHIFT (arithmetic).
  - If r > 32767, result = 32767 and saturation occurs; if r < -32768, result = -32768 and saturation occurs; otherwise result = r[15:0].
- Decimation:
  - Phase counter 0..DECIM-1 advances on every in_valid and wraps to 0.
  - A sample is kept only when in_valid=1 and phase==0, so the first sample after reset or clr is kept.
  - Non-kept samples have no effect on any output.
- Pipeline:
  - Edge 1 (edge where in_valid is sampled): the rounded/saturated kept sample is registered in stage 1, with its saturation bit.
  - Edge 2: the stage-1 sample is written into the FIFO, or dropped.
  - Latency into an empty FIFO: m_valid rises 2 cycles after the in_valid edge.
- Back-to-back in_valid every cycle is supported at full rate.
- FIFO:
  - Show-ahead: m_data always equals the head entry while m_valid=1.
  - m_valid = (level != 0).
  - A pop occurs on a clock edge where m_valid & m_ready.
  - When m_valid=0, m_data holds its last value (0 after reset).
  - level changes by +1 on write only, -1 on pop only, 0 on simultaneous write and pop.
- Full FIFO:
  - A write is accepted if a pop occurs on the same edge.
  - Otherwise the sample is dropped, drop_flag is set, and FIFO contents are unchanged.
- Pointers wrap modulo DEPTH; level never exceeds DEPTH.
- sat_flag is set on the same edge the saturated sample is written into the FIFO or dropped. Saturation on non-kept samples is ignored.
- clr (synchronous, priority over all other activity):
  - Empties the FIFO, sets phase=0, invalidates stage 1, and clears both flags.
  - An in_valid sample on the clr cycle is discarded.
  - The next in_valid after clr is kept.
- m_ready while m_valid=0 is ignored.
- No combinational path from m_ready to m_valid or m_data.

Test Plan:
- SHIFT=8, DECIM=1: in_data 384, -384, 127, -129 on consecutive cycles, m_ready=1 -> m_data 2, -1, 0, -1. First m_valid 2 cycles after the first in_valid; sat_flag=0.
- SHIFT=8, DECIM=1: in_data 0x7FFFFFFF then 0x80000000 -> m_data 32767 then -32768; sat_flag=1 from the edge the first sample enters the FIFO.
- DECIM=4, in_valid every cycle, in_data = 256*k for k=0..11 -> only k=0, 4, 8 emerge, as m_data 0, 4, 8; level peaks at 1 with m_ready=1.
- DEPTH=4, DECIM=1, m_ready=0, 6 samples -> level=4, the first 4 retained in order, drop_flag=1. Then m_ready=1 drains 4 entries and m_valid falls.
- Full FIFO with m_ready=1 and a new sample arriving at stage 2 on the same edge -> level stays 4, no drop, head advances.
- Mid-stream clr=1 for one cycle with level=3 and phase=2 -> level=0, m_valid=0, flags 0. The next in_valid sample is kept and appears 2 cycles later. Also assert rst_n=0 asynchronously mid-burst -> all outputs zero immediately.
